// File: rtl/inference_scheduler_pkg.sv
// Shared types for the inference scheduler: sample bytes, activations,
// class index and the controller state encoding.
package inference_scheduler_pkg;

  // One input byte, unsigned fixed point (3,5).
  typedef logic [7:0] data_t;

  // One accelerator activation, signed fixed point (1,15).
  typedef logic signed [15:0] act_t;

  localparam int CLASS_W = 4;
  typedef logic [CLASS_W-1:0] class_t;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_SCAN   = 3'd5,
    ST_RESULT = 3'd6
  } state_t;

endpackage

// File: rtl/inference_scheduler_argmax_seq.sv
// Sequential argmax over the accelerator activations, one element per cycle.
// A start pulse begins the scan; done is high during the final element's cycle,
// so the winner registers are final on the cycle after done.
module argmax_seq
  import inference_scheduler_pkg::*;
#(
  parameter int NUM_OUTPUTS = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  act_t [NUM_OUTPUTS-1:0]   act,
  output logic                     done,
  output class_t                   best_class,
  output act_t                     best_score
);

  localparam class_t K_LAST = class_t'(NUM_OUTPUTS - 1);

  logic   active;
  class_t k;
  act_t   cur;

  assign cur  = act[k];
  assign done = active && (k == K_LAST);

  // Walk k across the activations; element 0 seeds the winner and only a
  // strictly larger value displaces it, so ties keep the lowest index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active     <= 1'b0;
      k          <= '0;
      best_class <= '0;
      best_score <= '0;
    end else if (start) begin
      active <= 1'b1;
      k      <= '0;
    end else if (active) begin
      if ((k == '0) || (cur > best_score)) begin
        best_score <= cur;
        best_class <= k;
      end
      if (done) begin
        active <= 1'b0;
      end else begin
        k <= k + 1'b1;
      end
    end
  end

endmodule

// File: rtl/inference_scheduler.sv
// Inference scheduler: collects one input sample into a buffer, runs the
// accelerator (reset pulse, start pulse, watchdog-guarded wait), picks the
// winning class with argmax_seq and holds the result until it is taken.
//
// state  | meaning
// LOAD   | accept sample bytes into the buffer
// DRAIN  | discard an overlong sample until its last byte
// CLEAR  | hold accelerator in reset for CLR_CYCLES cycles
// START  | one-cycle accelerator start pulse
// WAIT   | wait for accelerator done, watchdog running
// SCAN   | argmax over the activations
// RESULT | present class/score until accepted
module inference_scheduler
  import inference_scheduler_pkg::*;
#(
  parameter int NUM_INPUTS     = 256,
  parameter int NUM_OUTPUTS    = 10,
  parameter int CLR_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  data_t                    in_data,
  input  logic                     in_last,
  output logic                     acc_rst,
  output logic                     acc_start,
  output data_t [NUM_INPUTS-1:0]   acc_inputs,
  input  logic                     acc_done,
  input  act_t [NUM_OUTPUTS-1:0]   acc_act,
  output logic                     res_valid,
  input  logic                     res_ready,
  output class_t                   res_class,
  output act_t                     res_score,
  output logic                     err_len,
  output logic                     err_timeout,
  output logic                     busy
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_INPUTS - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CLR_W-1:0] CLR_INIT = CLR_W'(CLR_CYCLES - 1);

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [WD_W-1:0]        wdog;
  logic [CLR_W-1:0]       clr_cnt;
  data_t [NUM_INPUTS-1:0] buffer;
  logic                   beat;
  logic                   scan_start;
  logic                   scan_done;

  assign beat       = in_valid && (state == ST_LOAD);
  assign scan_start = (state == ST_WAIT) && acc_done;

  assign in_ready   = (state == ST_LOAD) || (state == ST_DRAIN);
  assign acc_rst    = rst || (state == ST_CLEAR);
  assign acc_start  = (state == ST_START);
  assign res_valid  = (state == ST_RESULT);
  assign busy       = (state == ST_CLEAR) || (state == ST_START) ||
                      (state == ST_WAIT)  || (state == ST_SCAN);
  assign acc_inputs = buffer;

  // Sample buffer: written only by accepted LOAD beats, so the accelerator
  // sees a frozen image for the whole run (including timeout retries).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer <= '0;
    end else if (beat) begin
      buffer[idx] <= in_data;
    end
  end

  // Sequencing FSM with byte index, clear down-counter and WAIT watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_LOAD;
      idx         <= '0;
      wdog        <= '0;
      clr_cnt     <= '0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (beat) begin
            if (in_last) begin
              idx <= '0;
              if (idx == IDX_LAST) begin
                state   <= ST_CLEAR;
                clr_cnt <= CLR_INIT;
              end else begin
                err_len <= 1'b1;
              end
            end else if (idx == IDX_LAST) begin
              err_len <= 1'b1;
              idx     <= '0;
              state   <= ST_DRAIN;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (in_valid && in_last) begin
            state <= ST_LOAD;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt == '0) begin
            state <= ST_START;
          end else begin
            clr_cnt <= clr_cnt - 1'b1;
          end
        end
        ST_START: begin
          state <= ST_WAIT;
          wdog  <= '0;
        end
        ST_WAIT: begin
          // done is tested first so it wins over a coincident timeout
          if (acc_done) begin
            state <= ST_SCAN;
          end else if (wdog == WD_LAST) begin
            err_timeout <= 1'b1;
            state       <= ST_CLEAR;
            clr_cnt     <= CLR_INIT;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        ST_SCAN: begin
          if (scan_done) begin
            state <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            state <= ST_LOAD;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  argmax_seq #(
    .NUM_OUTPUTS (NUM_OUTPUTS)
  ) u_argmax (
    .clk        (clk),
    .rst        (rst),
    .start      (scan_start),
    .act        (acc_act),
    .done       (scan_done),
    .best_class (res_class),
    .best_score (res_score)
  );

endmodule

// File: tb/tb_inference_scheduler.sv
// Randomized scoreboard bench for inference_scheduler: expected results are
// queued when a sample is sent and checked by an independent monitor.
`timescale 1ns/1ps
module tb_inference_scheduler;
  import inference_scheduler_pkg::*;

  localparam int NI  = 256;
  localparam int NO  = 10;
  localparam int CLR = 2;
  localparam int TO  = 4096;

  typedef struct packed {
    class_t cls;
    act_t   score;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_last;
  data_t in_data;
  logic acc_rst, acc_start, acc_done;
  data_t [NI-1:0] acc_inputs;
  act_t  [NO-1:0] acc_act;
  logic res_valid, res_ready;
  class_t res_class;
  act_t res_score;
  logic err_len, err_timeout, busy;

  inference_scheduler #(
    .NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .CLR_CYCLES(CLR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .acc_rst(acc_rst), .acc_start(acc_start), .acc_inputs(acc_inputs),
    .acc_done(acc_done), .acc_act(acc_act),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class), .res_score(res_score),
    .err_len(err_len), .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  res_t exp_q[$];
  data_t [NI-1:0] exp_buf;
  act_t acts_m [NO];
  int beat_cyc = 0;

  // accelerator model controls
  bit done_en = 1'b1;
  int done_delay = 5;

  // event tracker state
  int cnt_start = 0, start_cyc = 0;
  int cnt_err_len = 0, errlen_long = 0;
  int cnt_to = 0, to_cyc = 0;
  int rst_run = 0, last_rst_len = 0;
  int cnt_rv = 0, rv_cyc = 0;
  logic errlen_prev = 1'b0, rv_prev = 1'b0;

  task automatic check(input string name, input longint got, input longint req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Reference: the largest value, then the first index holding it.
  function automatic res_t model(input act_t a [NO]);
    res_t r;
    act_t mx = a[0];
    for (int i = 1; i < NO; i++) if (a[i] > mx) mx = a[i];
    r.cls = '0;
    for (int i = NO - 1; i >= 0; i--) if (a[i] == mx) r.cls = class_t'(i);
    r.score = mx;
    return r;
  endfunction

  task automatic apply_acts();
    for (int i = 0; i < NO; i++) acc_act[i] = acts_m[i];
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Accelerator: raise done for one cycle done_delay cycles after start.
  initial begin
    acc_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && acc_start && done_en) begin
        repeat (done_delay) @(negedge clk);
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
      end
    end
  end

  // Event tracker: pulse counts, timestamps and acc_rst run lengths.
  initial forever begin
    @(negedge clk);
    if (rst === 1'b0) begin
      if (acc_start) begin cnt_start++; start_cyc = cyc; end
      if (err_len) cnt_err_len++;
      if (err_len && errlen_prev) errlen_long++;
      if (err_timeout) begin cnt_to++; to_cyc = cyc; end
      if (acc_rst) rst_run++;
      else if (rst_run != 0) begin last_rst_len = rst_run; rst_run = 0; end
      if (res_valid && !rv_prev) begin cnt_rv++; rv_cyc = cyc; end
    end else begin
      rst_run = 0;
    end
    errlen_prev = err_len;
    rv_prev = res_valid;
  end

  // Scoreboard monitor: compare every accepted result with the queue head.
  initial forever begin
    res_t e;
    @(negedge clk);
    if (rst === 1'b0 && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_result: got class %0d score %0d, required none", res_class, res_score);
      end else begin
        e = exp_q.pop_front();
        check("res_class", res_class, e.cls);
        check("res_score", res_score, e.score);
      end
    end
  end

  task automatic beat(input data_t d, input logic l);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    @(negedge clk);
    while (!in_ready && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_wait: got in_ready 0 for %0d cycles, required 1", t);
    end
    beat_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_sample(input int n, input int last_at, input bit gaps);
    for (int i = 0; i < n; i++) begin
      data_t d;
      d = data_t'($urandom);
      if (gaps && $urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
      if (i < NI) exp_buf[i] = d;
      beat(d, i == last_at);
    end
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin @(negedge clk); t++; end
    check("result_wait", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic good_sample(input int delay, input bit gaps);
    done_delay = delay;
    apply_acts();
    exp_q.push_back(model(acts_m));
    run_sample(NI, NI - 1, gaps);
    @(negedge clk);
    check("acc_inputs", acc_inputs == exp_buf, 1);
    @(posedge clk); #1;
    wait_drain(6000);
  endtask

  task automatic rand_acts();
    for (int i = 0; i < NO; i++) acts_m[i] = act_t'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      acts_m[$urandom_range(0, NO - 1)] = 16'sh7FFF;
      acts_m[$urandom_range(0, NO - 1)] = 16'sh7FFF;
    end
  endtask

  initial begin
    #3ms;
    n_bad++;
    $display("FAIL global_timeout: got no end of run, required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int s0, e0, t0, rv0, lat, t, bad;
    res_t r;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; res_ready = 1'b1;
    for (int i = 0; i < NO; i++) acts_m[i] = '0;
    apply_acts();
    exp_buf = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_acc_rst", acc_rst, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_class", res_class, 0);
    check("rst_res_score", res_score, 0);
    check("rst_acc_start", acc_start, 0);
    check("rst_err_len", err_len, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_acc_inputs", acc_inputs == '0, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    check("rel_acc_rst", acc_rst, 0);
    @(posedge clk); #1;

    // Basic sample with a known winner and latency
    for (int i = 0; i < NO; i++) acts_m[i] = 16'sh1000;
    acts_m[3] = 16'sh7000;
    s0 = cnt_start;
    good_sample(300, 1'b0);
    lat = rv_cyc - beat_cyc;
    check("latency", lat, CLR + 1 + 300 + NO + 1);
    check("start_pulses", cnt_start - s0, 1);

    // Tie between two maxima
    for (int i = 0; i < NO; i++) acts_m[i] = act_t'(int'($urandom_range(0, 24575)) - 12288);
    acts_m[2] = 16'sh6000;
    acts_m[7] = 16'sh6000;
    good_sample($urandom_range(1, 40), 1'b1);

    // Short sample: length error, no accelerator run
    s0 = cnt_start; e0 = cnt_err_len;
    run_sample(11, 10, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("short_err_len", cnt_err_len - e0, 1);
    check("short_no_start", cnt_start - s0, 0);
    check("short_busy", busy, 0);
    rand_acts();
    good_sample($urandom_range(1, 40), 1'b1);

    // Overlong sample: length error, drain, recover
    s0 = cnt_start; e0 = cnt_err_len;
    run_sample(NI + 4, NI + 3, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("long_err_len", cnt_err_len - e0, 1);
    check("long_no_start", cnt_start - s0, 0);
    check("long_in_ready", in_ready, 1);
    rand_acts();
    good_sample($urandom_range(1, 40), 1'b0);

    // Watchdog timeout and retry
    rand_acts();
    apply_acts();
    done_en = 1'b0;
    done_delay = $urandom_range(1, 40);
    s0 = cnt_start; t0 = cnt_to;
    exp_q.push_back(model(acts_m));
    run_sample(NI, NI - 1, 1'b0);
    t = 0;
    while (cnt_to == t0 && t < TO + 200) begin @(negedge clk); t++; end
    done_en = 1'b1;
    check("timeout_seen", cnt_to - t0, 1);
    check("timeout_cycles", to_cyc - start_cyc, TO + 1);
    @(posedge clk); #1;
    wait_drain(1000);
    check("retry_acc_rst_len", last_rst_len, CLR);
    check("retry_start_pulses", cnt_start - s0, 2);
    check("retry_single_timeout", cnt_to - t0, 1);

    // Result backpressure
    rand_acts();
    apply_acts();
    r = model(acts_m);
    done_delay = $urandom_range(1, 40);
    res_ready = 1'b0;
    exp_q.push_back(r);
    run_sample(NI, NI - 1, 1'b1);
    t = 0;
    while (!res_valid && t < 2000) begin @(negedge clk); t++; end
    check("bp_res_valid", res_valid, 1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!res_valid || res_class != r.cls || res_score != r.score || in_ready) bad++;
    end
    check("bp_stable_violations", bad, 0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_drain(100);

    // Randomized samples
    for (int n = 0; n < 5; n++) begin
      rand_acts();
      good_sample($urandom_range(1, 60), 1'b1);
    end

    // Reset while waiting on the accelerator
    rand_acts();
    apply_acts();
    done_en = 1'b0;
    s0 = cnt_start;
    run_sample(NI, NI - 1, 1'b0);
    t = 0;
    while (cnt_start == s0 && t < 100) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    check("wait_busy", busy, 1);
    check("wait_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_acc_rst", acc_rst, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_buffer", acc_inputs == '0, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    s0 = cnt_start; rv0 = cnt_rv;
    done_en = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    repeat (50) @(negedge clk);
    check("post_rst_no_result", cnt_rv - rv0, 0);
    check("post_rst_no_start", cnt_start - s0, 0);
    @(posedge clk); #1;
    rand_acts();
    good_sample($urandom_range(1, 40), 1'b0);

    check("err_len_one_cycle", errlen_long, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
